// File: rtl/text_buf_pkg.sv
// Shared constants and FSM encoding for the text character buffer.
package text_buf_pkg;

    localparam int unsigned DEF_COLS  = 20;
    localparam int unsigned DEF_ROWS  = 8;
    localparam int unsigned DEF_COL_W = 7;
    localparam int unsigned DEF_ROW_W = 5;
    localparam int unsigned CHAR_W    = 7;

    localparam logic [CHAR_W-1:0] CR        = 7'h0D;
    localparam logic [CHAR_W-1:0] LF        = 7'h0A;
    localparam logic [CHAR_W-1:0] BS        = 7'h08;
    localparam logic [CHAR_W-1:0] FF        = 7'h0C;
    localparam logic [CHAR_W-1:0] BLANK     = 7'h20;
    localparam logic [CHAR_W-1:0] PRINT_MIN = 7'h20;
    localparam logic [CHAR_W-1:0] PRINT_MAX = 7'h7E;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CLR_ALL  = 2'd1,
        CLR_LINE = 2'd2
    } state_e;

    function automatic logic is_print(input logic [CHAR_W-1:0] c);
        return (c >= PRINT_MIN) && (c <= PRINT_MAX);
    endfunction

endpackage

// File: rtl/text_char_buffer_char_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A same-address read and write in one cycle returns the old contents.
module char_ram #(
    parameter int unsigned DEPTH  = 160,
    parameter int unsigned WIDTH  = 7,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WIDTH-1:0]  wdata_i,
    input  logic              rd_clr_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WIDTH-1:0]  rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Output register forced to zero for reset and out-of-range reads.
    always_ff @(posedge clk) begin
        if (rd_clr_i) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/text_char_buffer.sv
// Character-cell frame store: terminal-style write side driving a cursor,
// independent 1-cycle-latency read side feeding the font ROM.
module text_char_buffer
    import text_buf_pkg::*;
#(
    parameter int unsigned COLS  = DEF_COLS,
    parameter int unsigned ROWS  = DEF_ROWS,
    parameter int unsigned COL_W = DEF_COL_W,
    parameter int unsigned ROW_W = DEF_ROW_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [6:0]        wr_char,
    input  logic [ROW_W-1:0]  rd_row,
    input  logic [COL_W-1:0]  rd_col,
    output logic [6:0]        rd_char,
    output logic [ROW_W-1:0]  cursor_row,
    output logic [COL_W-1:0]  cursor_col,
    output logic              busy
);

    localparam int unsigned CELLS  = ROWS * COLS;
    localparam int unsigned ADDR_W = $clog2(CELLS);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               ready_q, busy_q;

    logic               accept_c;
    logic [ROW_W-1:0]   row_inc_c;
    logic [ADDR_W-1:0]  row_base_c, cur_addr_c;
    logic               ram_we_c;
    logic [ADDR_W-1:0]  ram_waddr_c;
    logic [6:0]         ram_wdata_c;
    logic               rd_oob_c;
    logic [ADDR_W-1:0]  rd_addr_c;

    assign accept_c   = wr_valid & ready_q;
    assign row_inc_c  = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
    assign row_base_c = ADDR_W'(row_q) * ADDR_W'(COLS);
    assign cur_addr_c = row_base_c + ADDR_W'(col_q);

    // Next-state, cursor and RAM write-port decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        ram_we_c    = 1'b0;
        ram_waddr_c = '0;
        ram_wdata_c = BLANK;

        case (state_q)
            CLR_ALL: begin
                ram_we_c    = 1'b1;
                ram_waddr_c = cnt_q;
                if (cnt_q == ADDR_W'(CELLS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

            // row_q already points at the row being cleared.
            CLR_LINE: begin
                ram_we_c    = 1'b1;
                ram_waddr_c = row_base_c + cnt_q;
                if (cnt_q == ADDR_W'(COLS - 1)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end

            IDLE: begin
                if (accept_c) begin
                    if (is_print(wr_char)) begin
                        ram_we_c    = 1'b1;
                        ram_waddr_c = cur_addr_c;
                        ram_wdata_c = wr_char;
                        if (col_q == COL_W'(COLS - 1)) begin
                            col_d   = '0;
                            row_d   = row_inc_c;
                            state_d = CLR_LINE;
                        end else begin
                            col_d = col_q + COL_W'(1);
                        end
                    end else begin
                        case (wr_char)
                            CR: col_d = '0;
                            LF: begin
                                row_d   = row_inc_c;
                                state_d = CLR_LINE;
                            end
                            BS: begin
                                if (col_q != '0) begin
                                    col_d       = col_q - COL_W'(1);
                                    ram_we_c    = 1'b1;
                                    ram_waddr_c = cur_addr_c - ADDR_W'(1);
                                end
                            end
                            FF: begin
                                row_d   = '0;
                                col_d   = '0;
                                state_d = CLR_ALL;
                            end
                            default: ;
                        endcase
                    end
                end
            end

            default: state_d = CLR_ALL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLR_ALL;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            ready_q <= (state_d == IDLE);
            busy_q  <= (state_d != IDLE);
        end
    end

    // Read side runs every cycle regardless of the write FSM.
    assign rd_oob_c  = (rd_row >= ROW_W'(ROWS)) || (rd_col >= COL_W'(COLS));
    assign rd_addr_c = rd_oob_c ? '0 : (ADDR_W'(rd_row) * ADDR_W'(COLS) + ADDR_W'(rd_col));

    char_ram #(
        .DEPTH  (CELLS),
        .WIDTH  (7),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk      (clk),
        .we_i     (ram_we_c & ~reset),
        .waddr_i  (ram_waddr_c),
        .wdata_i  (ram_wdata_c),
        .rd_clr_i (reset | rd_oob_c),
        .raddr_i  (rd_addr_c),
        .rdata_o  (rd_char)
    );

    assign wr_ready   = ready_q;
    assign busy       = busy_q;
    assign cursor_row = row_q;
    assign cursor_col = col_q;

endmodule

// File: tb/tb_text_char_buffer.sv
// Bench for text_char_buffer: screen/cursor model plus directed and random traffic.
module tb_text_char_buffer;

    localparam int NC   = 20;
    localparam int NR   = 8;
    localparam int NCELL = NR * NC;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid;
    logic       wr_ready;
    logic [6:0] wr_char;
    logic [4:0] rd_row;
    logic [6:0] rd_col;
    logic [6:0] rd_char;
    logic [4:0] cursor_row;
    logic [6:0] cursor_col;
    logic       busy;

    always #5 clk = ~clk;

    text_char_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_char    (wr_char),
        .rd_row     (rd_row),
        .rd_col     (rd_col),
        .rd_char    (rd_char),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [6:0] scr [NR][NC];
    int  m_row, m_col, busy_left, exp_rd;
    bit  m_started, exp_rd_ok;

    task automatic blank_all();
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) scr[r][c] = 7'h20;
    endtask

    task automatic blank_row(input int r);
        for (int c = 0; c < NC; c++) scr[r][c] = 7'h20;
    endtask

    // A clear takes effect at once in the model; busy_left hides the transition.
    task automatic apply(input int ch);
        if (ch >= 32 && ch <= 126) begin
            scr[m_row][m_col] = 7'(ch);
            if (m_col == NC - 1) begin
                m_col = 0;
                m_row = (m_row + 1) % NR;
                blank_row(m_row);
                busy_left = NC;
            end else begin
                m_col++;
            end
        end else if (ch == 13) begin
            m_col = 0;
        end else if (ch == 10) begin
            m_row = (m_row + 1) % NR;
            blank_row(m_row);
            busy_left = NC;
        end else if (ch == 8) begin
            if (m_col > 0) begin
                m_col--;
                scr[m_row][m_col] = 7'h20;
            end
        end else if (ch == 12) begin
            m_row = 0;
            m_col = 0;
            blank_all();
            busy_left = NCELL;
        end
    endtask

    initial begin
        m_started = 1'b0; exp_rd_ok = 1'b0;
        busy_left = 0; m_row = 0; m_col = 0; exp_rd = 0;
        forever begin
            @(posedge clk);
            if (reset || int'(rd_row) >= NR || int'(rd_col) >= NC) begin
                exp_rd    = 0;
                exp_rd_ok = 1'b1;
            end else begin
                exp_rd    = int'(scr[int'(rd_row)][int'(rd_col)]);
                exp_rd_ok = m_started && (busy_left == 0);
            end
            if (reset) begin
                m_started = 1'b1;
                busy_left = NCELL;
                m_row = 0;
                m_col = 0;
                blank_all();
            end else if (m_started) begin
                if (busy_left > 0) busy_left--;
                else if (wr_valid) apply(int'(wr_char));
            end
        end
    end

    // Compare DUT against the model every cycle, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (m_started) begin
                chk("busy",       int'(busy),       int'(busy_left > 0));
                chk("wr_ready",   int'(wr_ready),   int'(busy_left == 0));
                chk("cursor_row", int'(cursor_row), m_row);
                chk("cursor_col", int'(cursor_col), m_col);
                if (exp_rd_ok) chk("rd_char", int'(rd_char), exp_rd);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [6:0] ch, input bit hold);
        int guard = 0;
        wr_char  = ch;
        wr_valid = 1'b1;
        while (!wr_ready && guard < 400) begin
            tick();
            guard++;
        end
        if (guard >= 400) chk("send_ready_timeout", int'(wr_ready), 1);
        tick();
        if (!hold) wr_valid = 1'b0;
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (busy && n < 1000) begin
            n++;
            tick();
        end
    endtask

    task automatic read_at(input int r, input int c, output int v);
        rd_row = 5'(r);
        rd_col = 7'(c);
        tick();
        v = int'(rd_char);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, v;
        logic [6:0] r7 [5];
        int fpga [4];
        fpga = '{'h46, 'h50, 'h47, 'h41};

        reset = 1'b1; wr_valid = 1'b0; wr_char = '0; rd_row = '0; rd_col = '0;
        tick(); tick();
        chk("rst_ready", int'(wr_ready), 0);
        chk("rst_busy",  int'(busy), 1);
        chk("rst_crow",  int'(cursor_row), 0);
        chk("rst_ccol",  int'(cursor_col), 0);
        chk("rst_rd",    int'(rd_char), 0);

        reset = 1'b0;
        count_busy(n);
        chk("clr_all_cycles", n, 160);
        chk("ready_after_clr", int'(wr_ready), 1);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                read_at(r, c, v);
                chk("init_blank", v, 'h20);
            end
        read_at(8, 0, v);
        chk("oob_row", v, 0);
        read_at(0, 20, v);
        chk("oob_col", v, 0);

        // "FPGA" with valid held high
        for (int i = 0; i < 4; i++) send(7'(fpga[i]), i < 3);
        chk("fpga_ccol", int'(cursor_col), 4);
        chk("fpga_crow", int'(cursor_row), 0);
        for (int c = 0; c < 4; c++) begin
            read_at(0, c, v);
            chk("fpga_cell", v, fpga[c]);
        end

        // 20 'X' from (0,0) wraps to row 1 and clears it
        send(7'h0D, 1'b0);
        for (int i = 0; i < 20; i++) send(7'h58, i < 19);
        chk("wrap_crow", int'(cursor_row), 1);
        chk("wrap_ccol", int'(cursor_col), 0);
        count_busy(n);
        chk("clr_line_cycles", n, 20);
        for (int c = 0; c < NC; c++) begin
            read_at(0, c, v);
            chk("row0_x", v, 'h58);
            read_at(1, c, v);
            chk("row1_blank", v, 'h20);
        end

        // cursor to (7,5), then LF wraps to row 0
        for (int i = 0; i < 6; i++) send(7'h0A, 1'b0);
        for (int i = 0; i < 5; i++) begin
            r7[i] = 7'($urandom_range(33, 126));
            send(r7[i], 1'b0);
        end
        chk("pre_lf_crow", int'(cursor_row), 7);
        chk("pre_lf_ccol", int'(cursor_col), 5);
        send(7'h0A, 1'b0);
        chk("lf_wrap_crow", int'(cursor_row), 0);
        chk("lf_wrap_ccol", int'(cursor_col), 5);
        count_busy(n);
        chk("lf_clr_cycles", n, 20);
        for (int c = 0; c < NC; c++) begin
            read_at(0, c, v);
            chk("lf_row0_blank", v, 'h20);
        end
        for (int c = 0; c < 5; c++) begin
            read_at(7, c, v);
            chk("row7_kept", v, int'(r7[c]));
        end
        for (int r = 1; r < NR; r++)
            for (int c = 0; c < NC; c++) read_at(r, c, v);

        // backspace
        send(7'h0D, 1'b0);
        send(7'h08, 1'b0);
        chk("bs_col0_ccol", int'(cursor_col), 0);
        chk("bs_col0_crow", int'(cursor_row), 0);
        send(7'h41, 1'b0);
        send(7'h42, 1'b0);
        send(7'h08, 1'b0);
        chk("bs_ccol", int'(cursor_col), 1);
        read_at(0, 1, v);
        chk("bs_cell", v, 'h20);
        read_at(0, 0, v);
        chk("bs_keep", v, 'h41);

        // form feed
        send(7'h0C, 1'b0);
        count_busy(n);
        chk("ff_cycles", n, 160);
        chk("ff_crow", int'(cursor_row), 0);
        chk("ff_ccol", int'(cursor_col), 0);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++) begin
                read_at(r, c, v);
                chk("ff_blank", v, 'h20);
            end

        // read/write collision on (0,0)
        rd_row = '0; rd_col = '0; wr_char = 7'h5A; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        chk("collide_old", int'(rd_char), 'h20);
        tick();
        chk("collide_new", int'(rd_char), 'h5A);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int p;
            p = int'($urandom_range(0, 99));
            if (p < 75)      wr_char = 7'($urandom_range(32, 126));
            else if (p < 80) wr_char = 7'h0D;
            else if (p < 85) wr_char = 7'h0A;
            else if (p < 92) wr_char = 7'h08;
            else if (p < 93) wr_char = 7'h0C;
            else             wr_char = 7'($urandom_range(0, 127));
            wr_valid = 1'($urandom_range(0, 1));
            rd_row   = 5'($urandom_range(0, 9));
            rd_col   = 7'($urandom_range(0, 22));
            tick();
        end
        wr_valid = 1'b0;
        count_busy(n);

        // reset in the middle of a line clear restarts the full clear
        send(7'h0A, 1'b0);
        tick(); tick(); tick();
        chk("mid_clr_busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        count_busy(n);
        chk("reset_restart_cycles", n, 160);
        chk("reset_crow", int'(cursor_row), 0);
        chk("reset_ccol", int'(cursor_col), 0);
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/text_char_buffer.md
Name: text_char_buffer

Overview:
Character-cell frame store for the NTSC text display. It replaces the hard-wired character selection in front of the font ROM.
- Write side: accepts an ASCII byte stream (from UART or CPU) over a valid/ready handshake and interprets it as a minimal terminal: cursor, CR, LF, BS, form-feed, line auto-clear.
- Read side: the display side presents text row/column and receives the stored character code one clock later. That code feeds the font ROM address.

Parameters:
COLS, 20, characters per text row (160 scaled pixels / 8)
ROWS, 8, text rows (16 scaled lines each)
COL_W, 7, width of column index ports
ROW_W, 5, width of row index ports
BLANK, 7'h20, fill code used by all clears

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_valid  in  1  wr_char valid
wr_ready  out  1  block can accept a character
wr_char  in  7  ASCII code
rd_row  in  ROW_W  display text row
rd_col  in  COL_W  display text column
rd_char  out  7  character at (rd_row, rd_col), 1-cycle latency
cursor_row  out  ROW_W  current cursor row
cursor_col  out  COL_W  current cursor column
busy  out  1  full-screen or line clear in progress

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset:
  - Outputs: cursor 0,0; rd_char 7'h00; wr_ready 0; busy 1.
  - FSM enters CLR_ALL.
  - Reset asserted mid-operation aborts any clear and restarts CLR_ALL.
- States:
  - IDLE: wr_ready=1.
  - CLR_ALL: writes BLANK to addresses 0..ROWS*COLS-1, one per cycle, over exactly ROWS*COLS cycles. Then cursor 0,0 and state IDLE.
  - CLR_LINE: writes BLANK to row cursor_row, cols 0..COLS-1, over COLS cycles. Then IDLE.
  - wr_ready=0 and busy=1 in both clear states.
- Transfer occurs when wr_valid and wr_ready are both high. Accepted codes:
  - 7'h20..7'h7E (printable):
    - Write to cursor cell; col+1.
    - If col was COLS-1: col=0, row=(row+1) mod ROWS, then CLR_LINE for the new row.
  - 7'h0D (CR): col=0. No write.
  - 7'h0A (LF): row=(row+1) mod ROWS, col unchanged, then CLR_LINE. Row ROWS-1 wraps to 0; no scrolling.
  - 7'h08 (BS): if col>0, col-1 and write BLANK there. At col 0: no-op, and no wrap to the previous row.
  - 7'h0C (FF): CLR_ALL, cursor home.
  - All other codes are accepted and discarded; the cursor is unchanged.
- Cursor outputs update the cycle after acceptance.
- Address: row*COLS+col; width clog2(ROWS*COLS). The multiply must be constant-foldable (COLS is a parameter).
- Read port:
  - Independent of the write FSM; always active, including during clears.
  - rd_char is registered, with latency of exactly 1 cycle.
  - rd_row>=ROWS or rd_col>=COLS returns 7'h00.
  - Read and write to the same address in the same cycle returns the old data.
- wr_ready deasserts the cycle after an accept that triggers a clear, so no back-to-back accept into a clear.
- Storage: ROWS*COLS x 7 bits, inferred as block RAM (no reset on array contents; the reset clear initialises them).

Decomposition:
- Package text_buf_pkg:
  - ASCII constants: CR, LF, BS, FF, BLANK, PRINT_MIN, PRINT_MAX.
  - FSM state encoding: IDLE, CLR_ALL, CLR_LINE.
  - Default COLS/ROWS.
- Sub-module char_ram: simple dual-port, 1 synchronous write port and 1 synchronous read port, parameterised depth/width, read-old-on-collision.
- The FSM, cursor and address logic live in text_char_buffer.

Test Plan:
- Reset, then hold wr_valid=0:
  - busy=1 and wr_ready=0 for exactly 160 cycles, then wr_ready=1.
  - Reading every cell (0..7, 0..19) returns 7'h20.
  - rd_row=8 returns 7'h00.
- Send "FPGA" (7'h46,7'h50,7'h47,7'h41) with wr_valid held high:
  - Cells (0,0..3) read 46,50,47,41 one cycle after the address is presented.
  - cursor_col=4.
- Send 20 printable 'X' from (0,0):
  - Row 0 is all 7'h58.
  - Cursor moves to (1,0), followed by 20 cycles with busy=1; row 1 reads 7'h20.
- Cursor at (7,5), send LF:
  - Cursor (0,5); row 0 cleared to 7'h20 within 20 cycles.
  - Rows 1..7 unchanged.
- BS tests:
  - BS at col 0 leaves the cursor unchanged.
  - "AB" then BS gives cursor col 1 and cell (r,1)=7'h20.
  - FF then causes 160 busy cycles, cursor (0,0), and an all-blank screen.
- Collision and reset:
  - Read (0,0) in the same cycle 'Z' is written there: old value, then 7'h5A on the next read.
  - Assert reset mid-CLR_LINE: CLR_ALL restarts with a full 160-cycle count.
